// File: rtl/i2c_temp_pkg.sv
// rtl/i2c_temp_pkg.sv - shared state encoding, register map and reset constants
package i2c_temp_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
    ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK, ST_IGNORE
  } state_t;

  localparam logic [3:0] REG_TEMP_MSB  = 4'h0;
  localparam logic [3:0] REG_TEMP_LSB  = 4'h1;
  localparam logic [3:0] REG_STATUS    = 4'h2;
  localparam logic [3:0] REG_CFG       = 4'h3;
  localparam logic [3:0] REG_THIGH_MSB = 4'h4;
  localparam logic [3:0] REG_THIGH_LSB = 4'h5;
  localparam logic [3:0] REG_TLOW_MSB  = 4'h6;
  localparam logic [3:0] REG_TLOW_LSB  = 4'h7;
  localparam logic [3:0] REG_ID        = 4'hB;

  localparam logic [15:0] T_HIGH_RST = 16'h2000;
  localparam logic [15:0] T_LOW_RST  = 16'h0500;

  // Pointer auto-increment wraps from the ID register back to temperature MSB
  function automatic logic [3:0] ptr_inc(input logic [3:0] p);
    return (p == REG_ID) ? 4'h0 : p + 4'h1;
  endfunction

endpackage

// File: rtl/i2c_bus_sampler.sv
// rtl/i2c_bus_sampler.sv - scl/sda synchronizers with edge, START and STOP detection
module i2c_bus_sampler (
  input  logic clk,
  input  logic rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  // Index 1 is the synchronized level, index 2 the same level one cycle older
  logic [2:0] r_scl;
  logic [2:0] r_sda;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl <= 3'b111;
      r_sda <= 3'b111;
    end else begin
      r_scl <= {r_scl[1:0], i_scl};
      r_sda <= {r_sda[1:0], i_sda};
    end
  end

  assign o_sda      = r_sda[1];
  assign o_scl_rise = r_scl[1] & ~r_scl[2];
  assign o_scl_fall = ~r_scl[1] & r_scl[2];
  assign o_start    = r_scl[1] & r_scl[2] & r_sda[2] & ~r_sda[1];
  assign o_stop     = r_scl[1] & r_scl[2] & ~r_sda[2] & r_sda[1];

endmodule

// File: rtl/i2c_temp_responder.sv
// rtl/i2c_temp_responder.sv - I2C responder exposing an ADT7420-style temperature register map
module i2c_temp_responder
  import i2c_temp_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h48,
  parameter logic [7:0] DEV_ID   = 8'hCB
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl,
  inout  wire         sda,
  input  logic [15:0] temp_in,
  input  logic        temp_valid,
  output logic [7:0]  cfg,
  output logic [15:0] t_high,
  output logic [15:0] t_low,
  output logic        over_temp,
  output logic        under_temp,
  output logic        busy,
  output logic        done,
  output logic        ack_err
);

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_cnt;
  logic [7:0]  r_shift;
  logic [3:0]  r_ptr;
  logic        r_rw, r_ack_phase, r_mack;
  logic [7:0]  r_cfg;
  logic [15:0] r_t_high, r_t_low, r_temp_shadow, r_pend_data;
  logic        r_pend_valid, r_over, r_under, r_busy, r_done, r_ack_err;
  logic        w_sda_s, w_scl_rise, w_scl_fall, w_start, w_stop, w_sda_oe;
  logic        w_last_bit, w_ack_state, w_ptr_ok;
  logic [7:0]  w_byte, w_rd_byte;
  logic [3:0]  w_ptr_nxt, w_rd_ptr;

  i2c_bus_sampler u_sampler (
    .clk       (clk),
    .rst       (rst),
    .i_scl     (scl),
    .i_sda     (sda),
    .o_sda     (w_sda_s),
    .o_scl_rise(w_scl_rise),
    .o_scl_fall(w_scl_fall),
    .o_start   (w_start),
    .o_stop    (w_stop)
  );

  assign w_byte      = {r_shift[6:0], w_sda_s};
  assign w_last_bit  = w_scl_rise && (r_cnt == 3'd7);
  assign w_ptr_ok    = (w_byte <= {4'h0, REG_ID});
  assign w_ack_state = (r_state == ST_ADDR_ACK) || (r_state == ST_PTR_ACK) ||
                       (r_state == ST_WDATA_ACK);
  assign w_ptr_nxt   = ptr_inc(r_ptr);
  // The byte loaded on leaving RDATA_ACK belongs to the already-incremented pointer
  assign w_rd_ptr    = (r_state == ST_RDATA_ACK) ? w_ptr_nxt : r_ptr;

  always_comb begin
    w_rd_byte = 8'h00;
    case (w_rd_ptr)
      REG_TEMP_MSB:  w_rd_byte = r_temp_shadow[15:8];
      REG_TEMP_LSB:  w_rd_byte = r_temp_shadow[7:0];
      REG_STATUS:    w_rd_byte = {2'b00, r_over, r_under, 4'h0};
      REG_CFG:       w_rd_byte = r_cfg;
      REG_THIGH_MSB: w_rd_byte = r_t_high[15:8];
      REG_THIGH_LSB: w_rd_byte = r_t_high[7:0];
      REG_TLOW_MSB:  w_rd_byte = r_t_low[15:8];
      REG_TLOW_LSB:  w_rd_byte = r_t_low[7:0];
      REG_ID:        w_rd_byte = DEV_ID;
      default:       w_rd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_stop) begin
      w_state_nxt = ST_IDLE;
    end else if (w_start) begin
      w_state_nxt = ST_ADDR;
    end else begin
      case (r_state)
        ST_ADDR:      if (w_last_bit)
                        w_state_nxt = (w_byte[7:1] == DEV_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
        ST_ADDR_ACK:  if (w_scl_fall && r_ack_phase)
                        w_state_nxt = r_rw ? ST_RDATA : ST_PTR;
        ST_PTR:       if (w_last_bit) w_state_nxt = w_ptr_ok ? ST_PTR_ACK : ST_IGNORE;
        ST_PTR_ACK:   if (w_scl_fall && r_ack_phase) w_state_nxt = ST_WDATA;
        ST_WDATA:     if (w_last_bit) w_state_nxt = ST_WDATA_ACK;
        ST_WDATA_ACK: if (w_scl_fall && r_ack_phase) w_state_nxt = ST_WDATA;
        ST_RDATA:     if (w_scl_fall && (r_cnt == 3'd7)) w_state_nxt = ST_RDATA_ACK;
        ST_RDATA_ACK: if (w_scl_fall) w_state_nxt = r_mack ? ST_RDATA : ST_IGNORE;
        default:      w_state_nxt = r_state;
      endcase
    end
  end

  // ACK is held low from the first scl fall in an ACK state until the next one
  always_comb begin
    w_sda_oe = 1'b0;
    if (w_ack_state)               w_sda_oe = r_ack_phase;
    else if (r_state == ST_RDATA)  w_sda_oe = ~r_shift[7];
  end

  assign sda = w_sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 3'd0;         r_shift <= 8'h00;       r_ptr <= 4'h0;
      r_rw <= 1'b0;          r_ack_phase <= 1'b0;    r_mack <= 1'b0;
      r_cfg <= 8'h00;        r_t_high <= T_HIGH_RST; r_t_low <= T_LOW_RST;
      r_temp_shadow <= 16'h0000; r_pend_data <= 16'h0000; r_pend_valid <= 1'b0;
      r_over <= 1'b0;        r_under <= 1'b0;        r_busy <= 1'b0;
      r_done <= 1'b0;        r_ack_err <= 1'b0;
    end else begin
      r_done    <= w_stop && r_busy;
      r_ack_err <= 1'b0;
      if (w_stop) r_busy <= 1'b0;
      if (w_ack_state && w_scl_fall) r_ack_phase <= 1'b1;

      case (r_state)
        ST_ADDR: if (w_scl_rise) begin
          r_shift <= w_byte;
          r_cnt   <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_rw <= w_sda_s;
            if (w_byte[7:1] == DEV_ADDR) r_busy <= 1'b1;
          end
        end
        ST_PTR: if (w_scl_rise) begin
          r_shift <= w_byte;
          r_cnt   <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            if (w_ptr_ok) r_ptr <= w_byte[3:0];
            else          r_ack_err <= 1'b1;
          end
        end
        ST_WDATA: if (w_scl_rise) begin
          r_shift <= w_byte;
          r_cnt   <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_ptr <= w_ptr_nxt;
            case (r_ptr)
              REG_CFG:       r_cfg          <= w_byte;
              REG_THIGH_MSB: r_t_high[15:8] <= w_byte;
              REG_THIGH_LSB: r_t_high[7:0]  <= w_byte;
              REG_TLOW_MSB:  r_t_low[15:8]  <= w_byte;
              REG_TLOW_LSB:  r_t_low[7:0]   <= w_byte;
              default:       ;
            endcase
          end
        end
        ST_ADDR_ACK: if (w_scl_fall && r_ack_phase && r_rw) r_shift <= w_rd_byte;
        ST_RDATA: if (w_scl_fall) begin
          r_shift <= {r_shift[6:0], 1'b0};
          r_cnt   <= r_cnt + 3'd1;
        end
        ST_RDATA_ACK: begin
          if (w_scl_rise) r_mack <= ~w_sda_s;
          if (w_scl_fall && r_mack) begin
            r_ptr   <= w_ptr_nxt;
            r_shift <= w_rd_byte;
          end
        end
        default: ;
      endcase

      if (w_start || (w_state_nxt != r_state)) begin
        r_cnt       <= 3'd0;
        r_ack_phase <= 1'b0;
      end

      // Samples arriving mid-transaction are parked so multi-byte reads stay coherent
      if (temp_valid && !r_busy) begin
        r_temp_shadow <= temp_in;
        r_pend_valid  <= 1'b0;
      end else if (temp_valid) begin
        r_pend_data  <= temp_in;
        r_pend_valid <= 1'b1;
      end else if (r_pend_valid && !r_busy) begin
        r_temp_shadow <= r_pend_data;
        r_pend_valid  <= 1'b0;
      end

      r_over  <= $signed(r_temp_shadow) >= $signed(r_t_high);
      r_under <= $signed(r_temp_shadow) <= $signed(r_t_low);
    end
  end

  assign cfg        = r_cfg;
  assign t_high     = r_t_high;
  assign t_low      = r_t_low;
  assign over_temp  = r_over;
  assign under_temp = r_under;
  assign busy       = r_busy;
  assign done       = r_done;
  assign ack_err    = r_ack_err;

endmodule

// File: tb/tb_i2c_temp_responder.sv
// tb/tb_i2c_temp_responder.sv - scoreboard bench driving the responder as an I2C master
module tb_i2c_temp_responder;

  logic        clk;
  logic        rst;
  logic        m_scl;
  logic        m_sda_low;
  logic [15:0] temp_in;
  logic        temp_valid;
  logic [7:0]  cfg;
  logic [15:0] t_high, t_low;
  logic        over_temp, under_temp, busy, done, ack_err;
  wire         sda;

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  i2c_temp_responder dut (
    .clk       (clk),
    .rst       (rst),
    .scl       (m_scl),
    .sda       (sda),
    .temp_in   (temp_in),
    .temp_valid(temp_valid),
    .cfg       (cfg),
    .t_high    (t_high),
    .t_low     (t_low),
    .over_temp (over_temp),
    .under_temp(under_temp),
    .busy      (busy),
    .done      (done),
    .ack_err   (ack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] exp_q[$];
  string       name_q[$];
  logic [15:0] obs_q[$];
  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  always @(posedge clk) begin
    if (done)            done_cnt <= done_cnt + 1;
    if (ack_err)         err_cnt  <= err_cnt + 1;
    if (done && ack_err) both_cnt <= both_cnt + 1;
  end

  initial begin
    logic [15:0] act, e;
    string nm;
    forever begin
      @(negedge clk);
      while (obs_q.size() > 0) begin
        act = obs_q.pop_front();
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output: got %h with no expectation queued", act);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (act !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, e);
          end
        end
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_v(input string nm, input logic [15:0] v);
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  task automatic observe(input logic [15:0] v);
    obs_q.push_back(v);
  endtask

  task automatic check(input string nm, input logic [15:0] exp, input logic [15:0] act);
    expect_v(nm, exp);
    observe(act);
  endtask

  task automatic send_bit(input logic b);
    wait_n(3); m_sda_low = ~b;
    wait_n(7); m_scl = 1'b1;
    wait_n(10); m_scl = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    wait_n(3); m_sda_low = 1'b0;
    wait_n(7); m_scl = 1'b1;
    wait_n(5); b = sda;
    wait_n(5); m_scl = 1'b0;
  endtask

  task automatic i2c_start();
    wait_n(3); m_sda_low = 1'b0;
    wait_n(7); m_scl = 1'b1;
    wait_n(10); m_sda_low = 1'b1;
    wait_n(10); m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_n(3); m_sda_low = 1'b1;
    wait_n(7); m_scl = 1'b1;
    wait_n(10); m_sda_low = 1'b0;
    wait_n(10);
  endtask

  task automatic send_byte(input logic [7:0] v, input string nm, input logic exp_nack);
    logic a;
    expect_v(nm, {15'h0, exp_nack});
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    recv_bit(a);
    observe({15'h0, a});
  endtask

  task automatic read_byte(input string nm, input logic [7:0] exp, input logic nack);
    logic [7:0] b;
    logic bv;
    expect_v(nm, {8'h00, exp});
    for (int i = 7; i >= 0; i--) begin
      recv_bit(bv);
      b[i] = bv;
    end
    observe({8'h00, b});
    send_bit(nack);
  endtask

  task automatic strobe(input logic [15:0] v);
    temp_in = v; temp_valid = 1'b1;
    wait_n(1);
    temp_valid = 1'b0;
  endtask

  initial begin
    int d0, e0;
    logic bv;
    rst = 1'b1; m_scl = 1'b1; m_sda_low = 1'b0; temp_in = 16'h0; temp_valid = 1'b0;
    wait_n(4);
    check("rst_cfg",    16'h0000, {8'h00, cfg});
    check("rst_t_high", 16'h2000, t_high);
    check("rst_t_low",  16'h0500, t_low);
    check("rst_over",   16'h0000, {15'h0, over_temp});
    check("rst_under",  16'h0000, {15'h0, under_temp});
    check("rst_busy",   16'h0000, {15'h0, busy});
    check("rst_done",   16'h0000, {15'h0, done});
    check("rst_ack_err",16'h0000, {15'h0, ack_err});
    check("rst_sda",    16'h0001, {15'h0, sda});
    rst = 1'b0;
    wait_n(10);

    // ID register then wrap to temperature MSB (no strobe yet)
    i2c_start();
    send_byte(8'h90, "id_addr_ack", 1'b0);
    send_byte(8'h0B, "id_ptr_ack", 1'b0);
    i2c_start();
    send_byte(8'h91, "id_raddr_ack", 1'b0);
    read_byte("id_byte", 8'hCB, 1'b0);
    read_byte("wrap_temp_msb", 8'h00, 1'b1);
    i2c_stop();

    // cfg write
    d0 = done_cnt;
    i2c_start();
    send_byte(8'h90, "wr_addr_ack", 1'b0);
    send_byte(8'h03, "wr_ptr_ack", 1'b0);
    send_byte(8'hA5, "wr_data_ack", 1'b0);
    check("wr_busy", 16'h0001, {15'h0, busy});
    i2c_stop();
    check("wr_cfg", 16'h00A5, {8'h00, cfg});
    check("wr_done_once", 16'h0001, 16'(done_cnt - d0));
    check("wr_busy_after", 16'h0000, {15'h0, busy});

    // temperature read via pointer write + repeated START
    strobe(16'h0C80);
    wait_n(4);
    check("t_over_low",  16'h0000, {15'h0, over_temp});
    check("t_under_low", 16'h0000, {15'h0, under_temp});
    i2c_start();
    send_byte(8'h90, "t_addr_ack", 1'b0);
    send_byte(8'h00, "t_ptr_ack", 1'b0);
    i2c_start();
    send_byte(8'h91, "t_raddr_ack", 1'b0);
    read_byte("t_msb", 8'h0C, 1'b0);
    read_byte("t_lsb", 8'h80, 1'b1);
    i2c_stop();

    // t_high burst, then status
    i2c_start();
    send_byte(8'h90, "th_addr_ack", 1'b0);
    send_byte(8'h04, "th_ptr_ack", 1'b0);
    send_byte(8'h0C, "th_msb_ack", 1'b0);
    send_byte(8'h00, "th_lsb_ack", 1'b0);
    i2c_stop();
    check("th_value", 16'h0C00, t_high);
    check("th_over",  16'h0001, {15'h0, over_temp});
    i2c_start();
    send_byte(8'h90, "st_addr_ack", 1'b0);
    send_byte(8'h02, "st_ptr_ack", 1'b0);
    i2c_start();
    send_byte(8'h91, "st_raddr_ack", 1'b0);
    read_byte("st_byte", 8'h20, 1'b1);
    i2c_stop();

    // wrong address ignored
    d0 = done_cnt;
    i2c_start();
    send_byte(8'h92, "bad_addr_nack", 1'b1);
    check("bad_addr_busy", 16'h0000, {15'h0, busy});
    i2c_stop();
    check("bad_addr_no_done", 16'h0000, 16'(done_cnt - d0));

    // out-of-range pointer NACKed, pointer kept at status
    d0 = done_cnt; e0 = err_cnt;
    i2c_start();
    send_byte(8'h90, "bp_addr_ack", 1'b0);
    send_byte(8'h0F, "bp_ptr_nack", 1'b1);
    check("bp_ack_err", 16'h0001, 16'(err_cnt - e0));
    i2c_stop();
    check("bp_done", 16'h0001, 16'(done_cnt - d0));
    i2c_start();
    send_byte(8'h91, "bp_raddr_ack", 1'b0);
    read_byte("bp_ptr_kept", 8'h20, 1'b1);
    i2c_stop();

    // strobe during a read stays invisible; reset mid-byte
    d0 = done_cnt;
    i2c_start();
    send_byte(8'h90, "co_addr_ack", 1'b0);
    send_byte(8'h00, "co_ptr_ack", 1'b0);
    i2c_start();
    send_byte(8'h91, "co_raddr_ack", 1'b0);
    read_byte("co_msb", 8'h0C, 1'b0);
    strobe(16'h1900);
    read_byte("co_lsb", 8'h80, 1'b0);
    for (int i = 0; i < 3; i++) recv_bit(bv);
    rst = 1'b1;
    wait_n(1);
    check("mr_busy",   16'h0000, {15'h0, busy});
    check("mr_sda",    16'h0001, {15'h0, sda});
    check("mr_cfg",    16'h0000, {8'h00, cfg});
    check("mr_t_high", 16'h2000, t_high);
    check("mr_t_low",  16'h0500, t_low);
    check("mr_over",   16'h0000, {15'h0, over_temp});
    check("mr_under",  16'h0000, {15'h0, under_temp});
    wait_n(2);
    rst = 1'b0; m_sda_low = 1'b0; m_scl = 1'b1;
    wait_n(10);
    check("mr_no_done", 16'h0000, 16'(done_cnt - d0));

    // pending strobe applied once the transaction ends
    i2c_start();
    send_byte(8'h90, "pd_addr_ack", 1'b0);
    send_byte(8'h00, "pd_ptr_ack", 1'b0);
    strobe(16'h1900);
    i2c_start();
    send_byte(8'h91, "pd_raddr_ack", 1'b0);
    read_byte("pd_held", 8'h00, 1'b1);
    i2c_stop();
    i2c_start();
    send_byte(8'h91, "pd_raddr2_ack", 1'b0);
    read_byte("pd_applied_msb", 8'h19, 1'b0);
    read_byte("pd_applied_lsb", 8'h00, 1'b1);
    i2c_stop();
    check("pulses_exclusive", 16'h0000, 16'(both_cnt));

    wait_n(20);
    n_vec++;
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d expected/%0d observed left, required 0/0",
               exp_q.size(), obs_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
